branch_seq_ctrl: RTL and testbench

- Sequences control-flow instructions through the registered branch-condition unit (1-cycle latency `br`) and resolves each to taken or not-taken.
- Computes branch/jump targets and link values.
- On a taken result, issues a PC redirect to fetch over a valid/ready handshake, then asserts a flush window for younger pipeline stages.
- Sits between decode/issue and fetch; it owns the branch unit's `instr`/`a`/`b` inputs.

---
 rtl/branch_seq_ctrl_pkg.sv | 28 ++
 rtl/branch_seq_ctrl_if.sv | 39 +++
 rtl/branch_seq_ctrl_target_gen.sv | 27 ++
 rtl/branch_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_branch_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_seq_ctrl_pkg.sv
// Shared constants, state encoding and RISC-V immediate extraction for the branch sequencer.
package branch_seq_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EVAL     = 3'd1,
    ST_DECIDE   = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_FLUSH    = 3'd4
  } state_e;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/branch_seq_ctrl_if.sv
// Issue, branch-unit, redirect and link signals of the branch sequencer.
// slave = controller view, master = surrounding pipeline view.
interface branch_seq_ctrl_if #(parameter int PC_W = 32);

  logic            issue_valid;
  logic            issue_ready;
  logic [31:0]     issue_instr;
  logic [PC_W-1:0] issue_pc;
  logic [31:0]     issue_rs1;
  logic [31:0]     issue_rs2;

  logic [31:0]     bu_instr;
  logic [31:0]     bu_a;
  logic [31:0]     bu_b;
  logic            bu_br;

  logic            redir_valid;
  logic            redir_ready;
  logic [PC_W-1:0] redir_pc;

  logic            flush;
  logic            link_valid;
  logic [4:0]      link_rd;
  logic [PC_W-1:0] link_data;
  logic            busy;

  modport slave (
    input  issue_valid, issue_instr, issue_pc, issue_rs1, issue_rs2, bu_br, redir_ready,
    output issue_ready, bu_instr, bu_a, bu_b, redir_valid, redir_pc,
           flush, link_valid, link_rd, link_data, busy
  );

  modport master (
    output issue_valid, issue_instr, issue_pc, issue_rs1, issue_rs2, bu_br, redir_ready,
    input  issue_ready, bu_instr, bu_a, bu_b, redir_valid, redir_pc,
           flush, link_valid, link_rd, link_data, busy
  );

endinterface

// File: rtl/branch_seq_ctrl_target_gen.sv
// Combinational branch/jump target and link (pc+4) computation from the held instruction.
module branch_target_gen
  import branch_seq_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     rs1,
  output logic [PC_W-1:0] target,
  output logic [PC_W-1:0] link_data
);

  logic [31:0] jalr_sum;

  always_comb begin
    jalr_sum  = rs1 + imm_i(instr);
    link_data = pc + PC_W'(4);
    target    = pc + PC_W'($signed(imm_b(instr)));
    case (instr[6:0])
      OPC_JAL:  target = pc + PC_W'($signed(imm_j(instr)));
      OPC_JALR: target = PC_W'({jalr_sum[31:1], 1'b0});
      default:  target = pc + PC_W'($signed(imm_b(instr)));
    endcase
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch sequencer: drives the branch unit, resolves taken/not-taken, redirects fetch and flushes.
// Optional BRANCH_MISALIGN_TRAP_EN adds misalign_trap and blocks misaligned taken targets.
module branch_seq_ctrl
  import branch_seq_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input logic clk,
  input logic rst,
  branch_seq_ctrl_if.slave bus
`ifdef BRANCH_MISALIGN_TRAP_EN
  ,
  output logic misalign_trap
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_EVAL     = ST_EVAL;
  localparam logic [2:0] S_DECIDE   = ST_DECIDE;
  localparam logic [2:0] S_REDIRECT = ST_REDIRECT;
  localparam logic [2:0] S_FLUSH    = ST_FLUSH;

  logic [2:0]      state;
  logic [31:0]     h_instr;
  logic [31:0]     h_rs1;
  logic [31:0]     h_rs2;
  logic [PC_W-1:0] h_pc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] link_pc;
  logic [PC_W-1:0] redir_pc_q;
  logic [CNT_W-1:0] flush_cnt;
  logic            is_jump;
  logic            trap;
  logic            eval;
  logic            link_fire;

  branch_target_gen #(.PC_W(PC_W)) u_target_gen (
    .instr     (h_instr),
    .pc        (h_pc),
    .rs1       (h_rs1),
    .target    (target),
    .link_data (link_pc)
  );

  assign is_jump = (h_instr[6:0] == OPC_JAL) || (h_instr[6:0] == OPC_JALR);

`ifdef BRANCH_MISALIGN_TRAP_EN
  assign trap          = (state == S_DECIDE) && bus.bu_br && (target[1:0] != 2'b00);
  assign misalign_trap = !rst && trap;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      h_instr    <= '0;
      h_rs1      <= '0;
      h_rs2      <= '0;
      h_pc       <= '0;
      redir_pc_q <= '0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.issue_valid) begin
            h_instr <= bus.issue_instr;
            h_pc    <= bus.issue_pc;
            h_rs1   <= bus.issue_rs1;
            h_rs2   <= bus.issue_rs2;
            state   <= S_EVAL;
          end
        end
        S_EVAL: state <= S_DECIDE;
        S_DECIDE: begin
          if (bus.bu_br && !trap) begin
            redir_pc_q <= target;
            state      <= S_REDIRECT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REDIRECT: begin
          if (bus.redir_ready) begin
            if (FLUSH_CYCLES > 0) begin
              flush_cnt <= CNT_W'(FLUSH_CYCLES);
              state     <= S_FLUSH;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt - CNT_W'(1);
          if (flush_cnt == CNT_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so they read zero during reset, not only after it.
  assign eval      = !rst && (state == S_EVAL);
  assign link_fire = !rst && (state == S_DECIDE) && is_jump && (h_instr[11:7] != 5'd0) && !trap;

  assign bus.issue_ready = !rst && (state == S_IDLE);
  assign bus.bu_instr    = eval ? h_instr : '0;
  assign bus.bu_a        = eval ? h_rs1 : '0;
  assign bus.bu_b        = eval ? h_rs2 : '0;
  assign bus.redir_valid = !rst && (state == S_REDIRECT);
  assign bus.redir_pc    = rst ? '0 : redir_pc_q;
  assign bus.flush       = !rst && (state == S_FLUSH);
  assign bus.busy        = !rst && (state != S_IDLE);
  assign bus.link_valid  = link_fire;
  assign bus.link_rd     = link_fire ? h_instr[11:7] : '0;
  assign bus.link_data   = link_fire ? link_pc : '0;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl with a registered branch-unit model and a redirect/link scoreboard.
module tb_branch_seq_ctrl;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [36:0] exp_link[$];
  logic [31:0] exp_redir[$];
  logic [36:0] le;
  logic [31:0] re;

  branch_seq_ctrl_if #(.PC_W(32)) bus ();

`ifdef BRANCH_MISALIGN_TRAP_EN
  logic misalign_trap;
  branch_seq_ctrl #(.FLUSH_CYCLES(2), .PC_W(32)) dut (
    .clk (clk), .rst (rst), .bus (bus), .misalign_trap (misalign_trap)
  );
`else
  branch_seq_ctrl #(.FLUSH_CYCLES(2), .PC_W(32)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Branch unit reference: compares operands by funct3, jumps always taken, anything else not taken.
  function automatic logic bu_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic r;
    r = 1'b0;
    case (ins[6:0])
      7'b1100011: begin
        case (ins[14:12])
          3'b000:  r = (a == b);
          3'b001:  r = (a != b);
          3'b100:  r = ($signed(a) < $signed(b));
          3'b101:  r = ($signed(a) >= $signed(b));
          3'b110:  r = (a < b);
          3'b111:  r = (a >= b);
          default: r = 1'b0;
        endcase
      end
      7'b1101111, 7'b1100111: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always @(posedge clk) bus.bu_br <= rst ? 1'b0 : bu_model(bus.bu_instr, bus.bu_a, bus.bu_b);

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, rd, 7'b1100111};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.link_valid) begin
        if (exp_link.size() == 0) check_val("link_unexpected", 1, 0);
        else begin
          le = exp_link.pop_front();
          check_val("link_rd", bus.link_rd, le[36:32]);
          check_val("link_data", bus.link_data, le[31:0]);
        end
      end
      if (bus.redir_valid && bus.redir_ready) begin
        if (exp_redir.size() == 0) check_val("redir_unexpected", 1, 0);
        else begin
          re = exp_redir.pop_front();
          check_val("redir_pc_hs", bus.redir_pc, re);
        end
      end
    end
  end

  task automatic run_instr(input string name, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2, input bit taken,
                           input logic [31:0] tgt, input bit lnk, input logic [4:0] rd,
                           input logic [31:0] ldata, input int rdy_delay);
    bit trap_exp;
    int waited;
    trap_exp = 1'b0;
    waited   = 0;
`ifdef BRANCH_MISALIGN_TRAP_EN
    trap_exp = taken && (tgt[1:0] != 2'b00);
`endif
    while (!bus.issue_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check_val({name, "_ready_timeout"}, 0, 1);
    @(posedge clk); #1;
    bus.issue_valid = 1'b1;
    bus.issue_instr = instr;
    bus.issue_pc    = pc;
    bus.issue_rs1   = rs1;
    bus.issue_rs2   = rs2;
    bus.redir_ready = (rdy_delay == 0);
    if (lnk && !trap_exp) exp_link.push_back({rd, ldata});
    if (taken && !trap_exp) exp_redir.push_back(tgt);
    @(negedge clk);
    check_val({name, "_accept_ready"}, bus.issue_ready, 1);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    bus.issue_instr = '0;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
    @(negedge clk);
    check_val({name, "_eval_busy"}, bus.busy, 1);
    check_val({name, "_eval_instr"}, bus.bu_instr, instr);
    check_val({name, "_eval_a"}, bus.bu_a, rs1);
    @(negedge clk);
    check_val({name, "_decide_rv"}, bus.redir_valid, 0);
`ifdef BRANCH_MISALIGN_TRAP_EN
    check_val({name, "_trap"}, misalign_trap, trap_exp);
`endif
    @(negedge clk);
    if (taken && !trap_exp) begin
      check_val({name, "_rv"}, bus.redir_valid, 1);
      check_val({name, "_rpc"}, bus.redir_pc, tgt);
      check_val({name, "_noflush"}, bus.flush, 0);
      if (rdy_delay > 0) begin
        repeat (rdy_delay - 1) begin
          @(negedge clk);
          check_val({name, "_rv_hold"}, bus.redir_valid, 1);
          check_val({name, "_rpc_hold"}, bus.redir_pc, tgt);
          check_val({name, "_flush_early"}, bus.flush, 0);
        end
        @(posedge clk); #1;
        bus.redir_ready = 1'b1;
        @(negedge clk);
        check_val({name, "_rv_hs"}, bus.redir_valid, 1);
      end
      @(posedge clk); #1;
      bus.redir_ready = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check_val({name, "_flush"}, bus.flush, 1);
        check_val({name, "_rv_drop"}, bus.redir_valid, 0);
      end
      @(negedge clk);
      check_val({name, "_flush_end"}, bus.flush, 0);
      check_val({name, "_idle_ready"}, bus.issue_ready, 1);
    end else begin
      check_val({name, "_nt_rv"}, bus.redir_valid, 0);
      check_val({name, "_nt_flush"}, bus.flush, 0);
      check_val({name, "_nt_ready"}, bus.issue_ready, 1);
      check_val({name, "_nt_busy"}, bus.busy, 0);
      @(posedge clk); #1;
      bus.redir_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_instr = '0;
    bus.issue_pc    = '0;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
    bus.redir_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_issue_ready", bus.issue_ready, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_redir_valid", bus.redir_valid, 0);
    check_val("rst_flush", bus.flush, 0);
    check_val("rst_bu_instr", bus.bu_instr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", bus.issue_ready, 1);

    run_instr("beq",   enc_b(3'b000, 13'd16), 32'h100, 32'd5, 32'd5, 1, 32'h110, 0, 5'd0, 32'h0, 0);
    run_instr("bne_nt", enc_b(3'b001, 13'd16), 32'h180, 32'd7, 32'd7, 0, 32'h0, 0, 5'd0, 32'h0, 0);
    run_instr("jalr",  enc_jalr(5'd1, 12'd4), 32'h40, 32'h2003, 32'd0, 1, 32'h2006, 1, 5'd1, 32'h44, 1);
    run_instr("jal0",  enc_jal(5'd0, 21'h40), 32'h200, 32'd0, 32'd0, 1, 32'h240, 0, 5'd0, 32'h0, 4);
    run_instr("blt",   enc_b(3'b100, 13'd2), 32'h100, 32'hFFFF_FFFF, 32'd1, 1, 32'h102, 0, 5'd0, 32'h0, 0);
    run_instr("bne_back", enc_b(3'b001, 13'h1FF8), 32'h100, 32'd1, 32'd2, 1, 32'hF8, 0, 5'd0, 32'h0, 2);
    run_instr("jal5",  enc_jal(5'd5, 21'h1FFF00), 32'h1000, 32'd0, 32'd0, 1, 32'hF00, 1, 5'd5, 32'h1004, 0);
    run_instr("bgeu_nt", enc_b(3'b111, 13'd8), 32'h500, 32'd1, 32'd2, 0, 32'h0, 0, 5'd0, 32'h0, 0);
    run_instr("addi",  32'h0010_0093, 32'h600, 32'd3, 32'd3, 0, 32'h0, 0, 5'd0, 32'h0, 0);

    // Reset while a redirect is pending: the redirect must be abandoned.
    @(posedge clk); #1;
    bus.redir_ready = 1'b0;
    bus.issue_valid = 1'b1;
    bus.issue_instr = enc_b(3'b000, 13'd16);
    bus.issue_pc    = 32'h300;
    bus.issue_rs1   = 32'd9;
    bus.issue_rs2   = 32'd9;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rstmid_rv", bus.redir_valid, 1);
    check_val("rstmid_rpc", bus.redir_pc, 32'h310);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("rstmid_rv_off", bus.redir_valid, 0);
    check_val("rstmid_rpc_off", bus.redir_pc, 0);
    check_val("rstmid_flush", bus.flush, 0);
    check_val("rstmid_busy", bus.busy, 0);
    check_val("rstmid_ready", bus.issue_ready, 0);
    check_val("rstmid_link", bus.link_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rstmid_ready_after", bus.issue_ready, 1);
    check_val("rstmid_busy_after", bus.busy, 0);

    run_instr("beq_after", enc_b(3'b000, 13'd32), 32'h400, 32'd1, 32'd1, 1, 32'h420, 0, 5'd0, 32'h0, 1);

    repeat (3) @(negedge clk);
    check_val("link_queue_empty", exp_link.size(), 0);
    check_val("redir_queue_empty", exp_redir.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
